// File: rtl/buffer_escrita_pkg.sv
// rtl/buffer_escrita_pkg.sv - shared widths and entry record for the write buffer
package buffer_escrita_pkg;

   localparam int LARGURA_IDX  = 4;
   localparam int LARGURA_DADO = 16;

   typedef struct packed {
      logic [LARGURA_IDX-1:0]  idx;
      logic [LARGURA_DADO-1:0] dado;
   } entrada_t;

endpackage

// File: rtl/buffer_escrita_fifo_escrita.sv
// rtl/buffer_escrita_fifo_escrita.sv - storage, pointers and occupancy counter of the write buffer
// Ports: clk, rst (sync, active-high); push/entrada write one entry; pop retires the head;
//        cabeca = head entry; rd_ptr = head slot; contagem = valid entries; mem = raw storage.
module fifo_escrita
   import buffer_escrita_pkg::*;
#(
   parameter int PROFUNDIDADE = 4,
   localparam int PW = $clog2(PROFUNDIDADE),
   localparam int CW = PW + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  entrada_t      entrada,
   input  logic          pop,
   output entrada_t      cabeca,
   output logic [PW-1:0] rd_ptr,
   output logic [CW-1:0] contagem,
   output entrada_t      mem [PROFUNDIDADE]
);

   logic [PW-1:0] wr_ptr;

   // Power-of-two depth: pointers wrap by plain overflow.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         contagem <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         unique case ({push, pop})
            2'b10:   contagem <= contagem + CW'(1);
            2'b01:   contagem <= contagem - CW'(1);
            default: contagem <= contagem;
         endcase
      end
   end

   // Storage is not cleared; validity is purely the rd_ptr/contagem window.
   always_ff @(posedge clk) begin
      if (!rst && push) mem[wr_ptr] <= entrada;
   end

   assign cabeca = mem[rd_ptr];

endmodule

// File: rtl/buffer_escrita.sv
// rtl/buffer_escrita.sv - register-bank write buffer with optional read bypass (BUFFER_ESCRITA_BYPASS_EN)
// Ports: clk, rst (sync, active-high); req_valid/req_reg/req_dado/req_ready = request in;
//        banco_ocupado stalls drain; regC/dado/RW = bank write port; regA/regB = snooped reads;
//        hitA/hitB/bypassA/bypassB = pending-write bypass; vazio/cheio/contagem = occupancy.
module buffer_escrita
   import buffer_escrita_pkg::*;
#(
   parameter int PROFUNDIDADE = 4,
   localparam int PW = $clog2(PROFUNDIDADE),
   localparam int CW = PW + 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    req_valid,
   input  logic [LARGURA_IDX-1:0]  req_reg,
   input  logic [LARGURA_DADO-1:0] req_dado,
   output logic                    req_ready,
   input  logic                    banco_ocupado,
   output logic [LARGURA_IDX-1:0]  regC,
   output logic [LARGURA_DADO-1:0] dado,
   output logic                    RW,
   input  logic [LARGURA_IDX-1:0]  regA,
   input  logic [LARGURA_IDX-1:0]  regB,
   output logic                    hitA,
   output logic                    hitB,
   output logic [LARGURA_DADO-1:0] bypassA,
   output logic [LARGURA_DADO-1:0] bypassB,
   output logic                    vazio,
   output logic                    cheio,
   output logic [CW-1:0]           contagem
);

   entrada_t      cabeca;
   entrada_t      mem [PROFUNDIDADE];
   logic [PW-1:0] rd_ptr;
   logic          push;
   logic          pop;

   assign vazio     = (contagem == '0);
   assign cheio     = (contagem == CW'(PROFUNDIDADE));
   assign req_ready = !cheio;
   // Push is judged on pre-edge fullness, so a same-cycle pop never frees a slot.
   assign push      = req_valid && req_ready;
   assign RW        = !vazio && !banco_ocupado;
   assign pop       = RW;
   assign regC      = vazio ? '0 : cabeca.idx;
   assign dado      = vazio ? '0 : cabeca.dado;

   fifo_escrita #(.PROFUNDIDADE(PROFUNDIDADE)) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (push),
      .entrada  ('{idx: req_reg, dado: req_dado}),
      .pop      (pop),
      .cabeca   (cabeca),
      .rd_ptr   (rd_ptr),
      .contagem (contagem),
      .mem      (mem)
   );

`ifdef BUFFER_ESCRITA_BYPASS_EN
   logic [PW-1:0] pos;

   // Walk oldest to youngest so the last match (youngest) wins.
   always_comb begin
      hitA    = 1'b0;
      hitB    = 1'b0;
      bypassA = '0;
      bypassB = '0;
      pos     = '0;
      for (int k = 0; k < PROFUNDIDADE; k++) begin
         pos = rd_ptr + PW'(k);
         if (CW'(k) < contagem) begin
            if (mem[pos].idx == regA) begin
               hitA    = 1'b1;
               bypassA = mem[pos].dado;
            end
            if (mem[pos].idx == regB) begin
               hitB    = 1'b1;
               bypassB = mem[pos].dado;
            end
         end
      end
   end
`else
   logic unused_bypass;

   assign hitA    = 1'b0;
   assign hitB    = 1'b0;
   assign bypassA = '0;
   assign bypassB = '0;

   always_comb begin
      unused_bypass = ^{regA, regB, rd_ptr};
      for (int k = 0; k < PROFUNDIDADE; k++) unused_bypass = unused_bypass ^ (^mem[k]);
   end
`endif

endmodule

// File: tb/tb_buffer_escrita.sv
// tb/tb_buffer_escrita.sv - self-checking bench for buffer_escrita against a queue model
module tb_buffer_escrita;

   localparam int D = 4;
`ifdef BUFFER_ESCRITA_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   typedef struct packed {
      logic [3:0]  r;
      logic [15:0] d;
   } ent_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic [3:0]  req_reg;
   logic [15:0] req_dado;
   logic        req_ready;
   logic        banco_ocupado;
   logic [3:0]  regC;
   logic [15:0] dado;
   logic        RW;
   logic [3:0]  regA, regB;
   logic        hitA, hitB;
   logic [15:0] bypassA, bypassB;
   logic        vazio, cheio;
   logic [$clog2(D):0] contagem;

   int   total = 0;
   int   bad   = 0;
   ent_t m_q[$];

   buffer_escrita #(.PROFUNDIDADE(D)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_reg(req_reg), .req_dado(req_dado),
      .req_ready(req_ready), .banco_ocupado(banco_ocupado), .regC(regC), .dado(dado), .RW(RW),
      .regA(regA), .regB(regB), .hitA(hitA), .hitB(hitB), .bypassA(bypassA), .bypassB(bypassB),
      .vazio(vazio), .cheio(cheio), .contagem(contagem)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Expected outputs derived from the queue contents and current inputs.
   task automatic verifica(input string t);
      int          n;
      logic        ha, hb;
      logic [15:0] ba, bb;
      n  = m_q.size();
      ha = 1'b0; hb = 1'b0; ba = '0; bb = '0;
      for (int i = n - 1; i >= 0; i--) begin
         if (!ha && m_q[i].r == regA) begin ha = 1'b1; ba = m_q[i].d; end
         if (!hb && m_q[i].r == regB) begin hb = 1'b1; bb = m_q[i].d; end
      end
      chk({t, "_ready"},    32'(req_ready), 32'(n < D));
      chk({t, "_vazio"},    32'(vazio),     32'(n == 0));
      chk({t, "_cheio"},    32'(cheio),     32'(n == D));
      chk({t, "_contagem"}, 32'(contagem),  32'(n));
      chk({t, "_rw"},       32'(RW),        32'(n > 0 && !banco_ocupado));
      chk({t, "_regc"},     32'(regC),      32'(n > 0 ? m_q[0].r : 4'd0));
      chk({t, "_dado"},     32'(dado),      32'(n > 0 ? m_q[0].d : 16'd0));
      chk({t, "_hita"},     32'(hitA),      32'(BYP ? ha : 1'b0));
      chk({t, "_hitb"},     32'(hitB),      32'(BYP ? hb : 1'b0));
      chk({t, "_bypa"},     32'(bypassA),   32'(BYP ? ba : 16'd0));
      chk({t, "_bypb"},     32'(bypassB),   32'(BYP ? bb : 16'd0));
   endtask

   // One clock: drive at negedge, check, advance model at the rising edge.
   task automatic ciclo(input string t, input logic v, input logic [3:0] r, input logic [15:0] d,
                        input logic b, input logic [3:0] ra, input logic [3:0] rb, input logic rs);
      logic push_ok, pop_ok;
      req_valid = v; req_reg = r; req_dado = d; banco_ocupado = b;
      regA = ra; regB = rb; rst = rs;
      #1;
      if (!rs) verifica(t);
      push_ok = v && (m_q.size() < D);
      pop_ok  = (m_q.size() > 0) && !b;
      @(posedge clk);
      if (rs) m_q.delete();
      else begin
         if (pop_ok)  void'(m_q.pop_front());
         if (push_ok) m_q.push_back('{r: r, d: d});
      end
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1; req_valid = 1'b0; req_reg = '0; req_dado = '0;
      banco_ocupado = 1'b0; regA = '0; regB = '0;
      @(negedge clk);
      ciclo("rst", 0, 0, 0, 0, 0, 0, 1);
      ciclo("rst", 0, 0, 0, 0, 0, 0, 1);
      verifica("reset");

      // Single write, one-cycle latency to the bank.
      ciclo("lat_push", 1, 4'd3, 16'h1234, 0, 0, 0, 0);
      req_valid = 1'b0; #1;
      chk("lat_rw", 32'(RW), 32'd1);
      chk("lat_regc", 32'(regC), 32'd3);
      chk("lat_dado", 32'(dado), 32'h1234);
      ciclo("lat_drain", 0, 0, 0, 0, 0, 0, 0);
      chk("lat_vazio", 32'(vazio), 32'd1);

      // Fill while bank is busy; fifth request refused.
      for (int i = 0; i < 5; i++)
         ciclo("fill", 1, 4'(i + 8), 16'(16'hA000 + i), 1, 0, 0, 0);
      chk("fill_cnt", 32'(contagem), 32'd4);
      chk("fill_cheio", 32'(cheio), 32'd1);
      chk("fill_ready", 32'(req_ready), 32'd0);

      // Release busy with req_valid held: drain in order, refill across pointer wrap.
      for (int i = 0; i < 10; i++)
         ciclo("drain", 1, 4'(i), 16'(16'hB000 + i), 0, 4'(i), 4'(i + 1), 0);
      for (int i = 0; i < 6; i++)
         ciclo("drain_tail", 0, 0, 0, 0, 4'(i), 4'(i + 1), 0);
      chk("drain_vazio", 32'(vazio), 32'd1);

      // Two writes to reg 7: bypass shows the youngest.
      ciclo("byp", 1, 4'd7, 16'h0001, 1, 4'd7, 4'd0, 0);
      ciclo("byp", 1, 4'd7, 16'h0002, 1, 4'd7, 4'd0, 0);
      ciclo("byp_hold", 0, 0, 0, 1, 4'd7, 4'd0, 0);
      chk("byp_hita", 32'(hitA), 32'(BYP));
      chk("byp_bypa", 32'(bypassA), BYP ? 32'h0002 : 32'h0);
      for (int i = 0; i < 3; i++) ciclo("byp_drain", 0, 0, 0, 0, 4'd7, 4'd0, 0);
      chk("byp_after", 32'(hitA), 32'd0);

      // Reset with three queued writes.
      for (int i = 0; i < 3; i++) ciclo("rq", 1, 4'(i), 16'(16'hC000 + i), 1, 0, 0, 0);
      ciclo("rq_rst", 1, 4'd9, 16'hDEAD, 0, 0, 0, 1);
      chk("rq_rw", 32'(RW), 32'd0);
      chk("rq_cnt", 32'(contagem), 32'd0);
      for (int i = 0; i < 4; i++) ciclo("rq_after", 0, 0, 0, 0, 0, 0, 0);

      // Random traffic.
      for (int i = 0; i < 400; i++)
         ciclo("rnd", 1'($urandom_range(0, 1)), 4'($urandom_range(0, 3)), 16'($urandom),
               1'($urandom_range(0, 9) < 3), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
               1'($urandom_range(0, 49) == 0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
